alu_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle combinational ALU in the receiver datapath. It accepts one operation per cycle through a valid/ready handshake and computes in a 2N-bit intermediate. It applies per-instruction saturation or high-half selection, and returns an N-bit result with status flags after a fixed two-cycle latency. Full back-pressure is supported. A sticky saturation counter is provided for DSP gain monitoring.

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Request/response bundle of the pipelined ALU: operation handshake in, result handshake out.
interface alu_pipe_if #(
    parameter int N = 16,
    parameter int S = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          op;
    logic                sat;
    logic signed [N-1:0] a;
    logic signed [N-1:0] b;
    logic [S-1:0]        shift;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] result;
    logic                sat_flag;
    logic                zero;

    modport master (
        output in_valid, op, sat, a, b, shift, out_ready,
        input  in_ready, out_valid, result, sat_flag, zero
    );

    modport slave (
        input  in_valid, op, sat, a, b, shift, out_ready,
        output in_ready, out_valid, result, sat_flag, zero
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: stage 1 forms a 2N-bit intermediate, stage 2 saturates or
// selects the result half and derives flags. Sticky saturation-event counter alongside.
module alu_pipe #(
    parameter int N  = 16,
    parameter int S  = 5,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_pipe_if.slave     bus,
    input  logic          sat_clr,
    output logic [CW-1:0] sat_count
);
    localparam int W = 2 * N;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHLA = 4'd7;
    localparam logic [3:0] OP_SHRA = 4'd8;
    localparam logic [3:0] OP_SHRL = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;

    // Native SV shifts already yield 0 (or all-sign for >>>) once the amount reaches W.
    function automatic logic signed [W-1:0] stage1_calc(
        input logic [3:0]          op,
        input logic signed [N-1:0] a,
        input logic signed [N-1:0] b,
        input logic [S-1:0]        sh
    );
        logic signed [W-1:0] a_ext;
        logic signed [W-1:0] b_ext;
        logic signed [W-1:0] a_sh;
        logic [W-1:0]        b_zx;
        logic [W-1:0]        aa;
        logic [31:0]         rot;
        a_ext = {{N{a[N-1]}}, a};
        b_ext = {{N{b[N-1]}}, b};
        b_zx  = {{N{1'b0}}, b};
        aa    = {a, a};
        a_sh  = a_ext << sh;
        rot   = 32'(sh) % 32'(N);
        case (op)
            OP_ADD:  return a_sh + b_ext;
            OP_SUB:  return b_ext - a_sh;
            OP_MUL:  return a_ext * b_ext;
            OP_AND:  return {{N{1'b0}}, a & b};
            OP_OR:   return {{N{1'b0}}, a | b};
            OP_XOR:  return {{N{1'b0}}, a ^ b};
            OP_SHLA: return a_sh;
            OP_SHRA: return a_ext >>> sh;
            OP_SHRL: return b_zx >> sh;
            OP_ROL: begin
                aa = aa << rot;
                return {{N{1'b0}}, aa[W-1:N]};
            end
            OP_ROR: begin
                aa = aa >> rot;
                return {{N{1'b0}}, aa[N-1:0]};
            end
            default: return '0;
        endcase
    endfunction

    // Returns {sat_flag, result}. Only ADD/SUB/MUL honour sat; MUL without sat takes the high half.
    function automatic logic [N:0] saturate(
        input logic [3:0]          op,
        input logic                sat,
        input logic signed [W-1:0] tmp
    );
        logic signed [W-1:0] maxv;
        logic signed [W-1:0] minv;
        logic                arith;
        maxv  = {{(N+1){1'b0}}, {(N-1){1'b1}}};
        minv  = {{(N+1){1'b1}}, {(N-1){1'b0}}};
        arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
        if (arith && sat) begin
            if (tmp > maxv) return {1'b1, maxv[N-1:0]};
            if (tmp < minv) return {1'b1, minv[N-1:0]};
            return {1'b0, tmp[N-1:0]};
        end
        if (op == OP_MUL) return {1'b0, tmp[W-1:N]};
        return {1'b0, tmp[N-1:0]};
    endfunction

    logic                vld_p1_q;
    logic [3:0]          op_p1_q;
    logic                sat_p1_q;
    logic signed [W-1:0] tmp_p1_q;
    logic signed [W-1:0] tmp_p1_d;

    logic                vld_p2_q;
    logic signed [N-1:0] res_p2_q;
    logic signed [N-1:0] res_p2_d;
    logic                flag_p2_q;
    logic                flag_p2_d;
    logic                zero_p2_q;
    logic                zero_p2_d;

    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                s1_adv;
    logic                s2_adv;

    always_comb begin
        s2_adv = !vld_p2_q || bus.out_ready;
        s1_adv = !vld_p1_q || s2_adv;
    end

    assign bus.in_ready = s1_adv;

    // ---- stage 1: operand capture and 2N-bit intermediate ----
    always_comb begin
        tmp_p1_d = stage1_calc(bus.op, bus.a, bus.b, bus.shift);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else if (s1_adv) begin
            vld_p1_q <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && bus.in_valid) begin
            op_p1_q  <= bus.op;
            sat_p1_q <= bus.sat;
            tmp_p1_q <= tmp_p1_d;
        end
    end

    // ---- stage 2: saturation / half select, flags ----
    always_comb begin
        {flag_p2_d, res_p2_d} = saturate(op_p1_q, sat_p1_q, tmp_p1_q);
        zero_p2_d             = (res_p2_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q  <= 1'b0;
            res_p2_q  <= '0;
            flag_p2_q <= 1'b0;
            zero_p2_q <= 1'b0;
        end else if (s2_adv) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                res_p2_q  <= res_p2_d;
                flag_p2_q <= flag_p2_d;
                zero_p2_q <= zero_p2_d;
            end
        end
    end

    assign bus.out_valid = vld_p2_q;
    assign bus.result    = res_p2_q;
    assign bus.sat_flag  = flag_p2_q;
    assign bus.zero      = zero_p2_q;

    // Clear wins over a same-cycle clipped transfer; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (vld_p2_q && bus.out_ready && flag_p2_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table, back-pressure stream, reset flush, counter corners.
module tb_alu_pipe;
    localparam int N  = 16;
    localparam int S  = 5;
    localparam int CW = 8;
    localparam int NV = 22;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHLA = 4'd7;
    localparam logic [3:0] OP_SHRA = 4'd8;
    localparam logic [3:0] OP_SHRL = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;

    typedef struct {
        logic [3:0]  op;
        logic        sat;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  sh;
        logic [15:0] res;
        logic        flag;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sat_clr = 1'b0;
    logic [CW-1:0] sat_count;

    vec_t vt [NV];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.N(N), .S(S)) bus ();

    alu_pipe #(.N(N), .S(S), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.op    = v.op;
        bus.sat   = v.sat;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.shift = v.sh;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            inflight;
        int            rcv;
        int            stale;
        logic          acc;
        int            g;
        int            cyc;
        logic          prev_stall;
        logic [15:0]   prev_res;
        logic          prev_flag;

        vt[0]  = '{OP_ADD,  1'b1, 16'h4000, 16'h4000, 5'd0,  16'h7FFF, 1'b1};
        vt[1]  = '{OP_SUB,  1'b1, 16'h0001, 16'h8000, 5'd0,  16'h8000, 1'b1};
        vt[2]  = '{OP_SUB,  1'b0, 16'h0001, 16'h8000, 5'd0,  16'h7FFF, 1'b0};
        vt[3]  = '{OP_MUL,  1'b0, 16'h7FFF, 16'h7FFF, 5'd0,  16'h3FFF, 1'b0};
        vt[4]  = '{OP_MUL,  1'b1, 16'h7FFF, 16'h7FFF, 5'd0,  16'h7FFF, 1'b1};
        vt[5]  = '{OP_MUL,  1'b1, 16'hFFFE, 16'h0003, 5'd0,  16'hFFFA, 1'b0};
        vt[6]  = '{OP_ROL,  1'b0, 16'h8001, 16'h0000, 5'd1,  16'h0003, 1'b0};
        vt[7]  = '{OP_ROR,  1'b0, 16'h8001, 16'h0000, 5'd1,  16'hC000, 1'b0};
        vt[8]  = '{OP_SHRA, 1'b0, 16'h8000, 16'h0000, 5'd31, 16'hFFFF, 1'b0};
        vt[9]  = '{OP_SHRL, 1'b0, 16'h0000, 16'h8000, 5'd15, 16'h0001, 1'b0};
        vt[10] = '{OP_AND,  1'b1, 16'h00FF, 16'h0F0F, 5'd0,  16'h000F, 1'b0};
        vt[11] = '{OP_OR,   1'b0, 16'h00F0, 16'h0F00, 5'd0,  16'h0FF0, 1'b0};
        vt[12] = '{OP_XOR,  1'b0, 16'hFFFF, 16'hFFFF, 5'd0,  16'h0000, 1'b0};
        vt[13] = '{OP_NOP,  1'b1, 16'h1234, 16'h5678, 5'd3,  16'h0000, 1'b0};
        vt[14] = '{4'd13,   1'b1, 16'h7FFF, 16'h7FFF, 5'd0,  16'h0000, 1'b0};
        vt[15] = '{OP_SHLA, 1'b1, 16'h4001, 16'h0000, 5'd1,  16'h8002, 1'b0};
        vt[16] = '{OP_ADD,  1'b0, 16'h0010, 16'h0001, 5'd4,  16'h0101, 1'b0};
        vt[17] = '{OP_ADD,  1'b1, 16'h0100, 16'h0000, 5'd8,  16'h7FFF, 1'b1};
        vt[18] = '{OP_SHLA, 1'b0, 16'h0001, 16'h0000, 5'd20, 16'h0000, 1'b0};
        vt[19] = '{OP_SHRA, 1'b0, 16'h4000, 16'h0000, 5'd31, 16'h0000, 1'b0};
        vt[20] = '{OP_ROL,  1'b0, 16'h1234, 16'h0000, 5'd20, 16'h2341, 1'b0};
        vt[21] = '{OP_SUB,  1'b1, 16'h0002, 16'h0005, 5'd1,  16'h0001, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(vt[13]);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", $unsigned(bus.result), 0);
        check("rst_sat_flag", bus.sat_flag, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_sat_count", sat_count, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;

        // Vector table, one op at a time: presented after edge k, visible after edge k+2
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_early", i), bus.out_valid, 0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            check($sformatf("vec%0d_result", i), $unsigned(bus.result), vt[i].res);
            check($sformatf("vec%0d_flag", i), bus.sat_flag, vt[i].flag);
            check($sformatf("vec%0d_zero", i), bus.zero, vt[i].res == 16'h0000);
        end
        @(posedge clk);
        @(negedge clk);
        check("table_sat_count", sat_count, 4);

        // Back-pressure stream: 20 ops, random out_ready
        inflight = 0;
        rcv      = 0;
        fork
            begin
                @(posedge clk);
                #1;
                for (int i = 0; i < 20; i++) begin
                    drive(vt[i % NV]);
                    bus.in_valid = 1'b1;
                    acc = 1'b0;
                    g   = 0;
                    while (!acc && g < 200) begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk);
                        #1;
                        g++;
                    end
                    check($sformatf("bp_accept%0d", i), acc, 1);
                end
                bus.in_valid = 1'b0;
            end
            begin
                cyc        = 0;
                prev_stall = 1'b0;
                prev_res   = '0;
                prev_flag  = 1'b0;
                while (rcv < 20 && cyc < 2000) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cyc++;
                    if (prev_stall) begin
                        check("bp_hold_valid", bus.out_valid, 1);
                        check("bp_hold_result", $unsigned(bus.result), prev_res);
                        check("bp_hold_flag", bus.sat_flag, prev_flag);
                    end
                    check("bp_in_ready", bus.in_ready, !(inflight == 2 && !bus.out_ready));
                    if (bus.out_valid && bus.out_ready) begin
                        check($sformatf("bp_result%0d", rcv), $unsigned(bus.result), vt[rcv % NV].res);
                        check($sformatf("bp_flag%0d", rcv), bus.sat_flag, vt[rcv % NV].flag);
                        rcv++;
                    end
                    inflight = inflight + int'(bus.in_valid && bus.in_ready)
                                        - int'(bus.out_valid && bus.out_ready);
                    prev_stall = bus.out_valid && !bus.out_ready;
                    prev_res   = bus.result;
                    prev_flag  = bus.sat_flag;
                end
                check("bp_delivered", rcv, 20);
            end
        join

        // Reset with two ops in flight
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        drive(vt[0]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(vt[6]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("inflight_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_result", $unsigned(bus.result), 0);
        check("midrst_flag", bus.sat_flag, 0);
        check("midrst_zero", bus.zero, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_sat_count", sat_count, 0);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("midrst_stale", stale, 0);

        // 300 saturating transfers: counter sticks at all-ones
        @(posedge clk);
        #1;
        drive(vt[0]);
        bus.in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sat_count_stuck", sat_count, 255);

        // sat_clr coincident with a saturating transfer
        @(posedge clk);
        #1;
        drive(vt[0]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("clr_out_valid", bus.out_valid, 1);
        check("clr_sat_flag", bus.sat_flag, 1);
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("clr_sat_count", sat_count, 0);
        check("clr_no_dup", bus.out_valid, 0);

        // Counting resumes after the clear
        @(posedge clk);
        #1;
        drive(vt[0]);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("post_clr_count", sat_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
